// File: rtl/grid_game_controller.sv
// grid_game_controller: N x N, K-in-a-row two-player board controller.
// Owns the board, the cursor, the turn order and the game FSM. Win detection
// scans outward from the last-placed cell, probing one cell per cycle.
//
// Ports:
//   clk, rst                    system clock, async active-high reset
//   up, down, left, right       debounced level-high cursor buttons
//   place                       place a piece at the cursor
//   new_game                    synchronous restart request (all states)
//   first_player                sampled in INIT: 0 = A moves first, 1 = B
//   rd_row, rd_col / rd_owner   renderer cell query (combinational)
//   cur_row, cur_col            cursor position, row 0 = top
//   turn                        player to move: 0 = A, 1 = B
//   move_count                  pieces on board
//   busy                        high while the win scan runs
//   winner, draw                result flags
//   state_q                     one-hot {DRAW, WIN, CHECK, WAIT_REL, WAIT_PRESS, INIT}
module grid_game_controller #(
  parameter int unsigned N  = 3,
  parameter int unsigned K  = 3,
  parameter int unsigned CW = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int unsigned MW = $clog2(N * N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          place,
  input  logic          new_game,
  input  logic          first_player,
  input  logic [CW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [1:0]    rd_owner,
  output logic [CW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          turn,
  output logic [MW-1:0] move_count,
  output logic          busy,
  output logic [1:0]    winner,
  output logic          draw,
  output logic [5:0]    state_q
);

  localparam int unsigned Cells = N * N;
  localparam int unsigned IW    = ($clog2(Cells) < 1) ? 1 : $clog2(Cells);
  localparam logic [CW-1:0] Centre = CW'(N / 2);
  localparam logic [CW-1:0] Last   = CW'(N - 1);

  typedef enum logic [5:0] {
    StInit      = 6'b000001,
    StWaitPress = 6'b000010,
    StWaitRel   = 6'b000100,
    StCheck     = 6'b001000,
    StWin       = 6'b010000,
    StDraw      = 6'b100000
  } state_t;

  state_t               fsm_q;
  logic [Cells-1:0][1:0] board_q;
  logic [CW-1:0]        cur_row_q, cur_col_q;
  logic                 turn_q;
  logic [MW-1:0]        move_count_q;
  logic [1:0]           winner_q;
  logic                 draw_q;

  // Scan state: anchor cell, direction, arm sign, probe distance, run length.
  logic [CW-1:0] pr_q, pc_q;
  logic [1:0]    dir_q;
  logic          neg_q;
  logic [3:0]    dist_q;
  logic [3:0]    cnt_q;

  logic [1:0] mover;
  assign mover = turn_q ? 2'b10 : 2'b01;

  // Cursor cell.
  logic [IW-1:0] cur_idx;
  assign cur_idx = IW'(int'(cur_row_q) * int'(N) + int'(cur_col_q));

  // Renderer read port.
  logic          rd_in;
  logic [IW-1:0] rd_idx;
  always_comb begin
    rd_in    = (int'(rd_row) < int'(N)) && (int'(rd_col) < int'(N));
    rd_idx   = rd_in ? IW'(int'(rd_row) * int'(N) + int'(rd_col)) : '0;
    rd_owner = rd_in ? board_q[rd_idx] : 2'b00;
  end

  // Probe cell for the current arm: anchor + sign * dist * (dr, dc).
  int            dr, dc, step, probe_r, probe_c;
  logic          probe_in;
  logic [IW-1:0] probe_idx;
  logic          match;
  always_comb begin
    dr = 0;
    dc = 0;
    unique case (dir_q)
      2'd0: begin dr = 0; dc = 1;  end
      2'd1: begin dr = 1; dc = 0;  end
      2'd2: begin dr = 1; dc = 1;  end
      2'd3: begin dr = 1; dc = -1; end
    endcase
    step      = neg_q ? -int'(dist_q) : int'(dist_q);
    probe_r   = int'(pr_q) + dr * step;
    probe_c   = int'(pc_q) + dc * step;
    probe_in  = (probe_r >= 0) && (probe_r < int'(N)) && (probe_c >= 0) && (probe_c < int'(N));
    probe_idx = probe_in ? IW'(probe_r * int'(N) + probe_c) : '0;
    match     = probe_in && (board_q[probe_idx] == mover);
  end

  logic any_btn;
  assign any_btn = up | down | left | right | place;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q        <= StInit;
      board_q      <= '0;
      cur_row_q    <= Centre;
      cur_col_q    <= Centre;
      turn_q       <= 1'b0;
      move_count_q <= '0;
      winner_q     <= 2'b00;
      draw_q       <= 1'b0;
      pr_q         <= '0;
      pc_q         <= '0;
      dir_q        <= 2'd0;
      neg_q        <= 1'b0;
      dist_q       <= 4'd1;
      cnt_q        <= 4'd1;
    end else if (new_game) begin
      fsm_q <= StInit;
    end else begin
      unique case (fsm_q)
        StInit: begin
          board_q      <= '0;
          cur_row_q    <= Centre;
          cur_col_q    <= Centre;
          turn_q       <= first_player;
          move_count_q <= '0;
          winner_q     <= 2'b00;
          draw_q       <= 1'b0;
          fsm_q        <= StWaitPress;
        end
        StWaitPress: begin
          if (any_btn) fsm_q <= StWaitRel;
          if (place) begin
            if (board_q[cur_idx] == 2'b00) begin
              board_q[cur_idx] <= mover;
              move_count_q     <= move_count_q + 1'b1;
              pr_q             <= cur_row_q;
              pc_q             <= cur_col_q;
              dir_q            <= 2'd0;
              neg_q            <= 1'b0;
              dist_q           <= 4'd1;
              cnt_q            <= 4'd1;
              fsm_q            <= StCheck;
            end
          end else if (right) begin
            cur_col_q <= (cur_col_q == Last) ? '0 : cur_col_q + 1'b1;
          end else if (left) begin
            cur_col_q <= (cur_col_q == '0) ? Last : cur_col_q - 1'b1;
          end else if (down) begin
            cur_row_q <= (cur_row_q == Last) ? '0 : cur_row_q + 1'b1;
          end else if (up) begin
            cur_row_q <= (cur_row_q == '0) ? Last : cur_row_q - 1'b1;
          end
        end
        StWaitRel: begin
          if (!any_btn) fsm_q <= StWaitPress;
        end
        StCheck: begin
          if (match && (int'(cnt_q) + 1 == int'(K))) begin
            winner_q <= mover;
            fsm_q    <= StWin;
          end else begin
            if (match) cnt_q <= cnt_q + 4'd1;
            // Arm continues only on a match short of K-1 steps.
            if (match && (int'(dist_q) < int'(K) - 1)) begin
              dist_q <= dist_q + 4'd1;
            end else if (!neg_q) begin
              neg_q  <= 1'b1;
              dist_q <= 4'd1;
            end else if (dir_q != 2'd3) begin
              dir_q  <= dir_q + 2'd1;
              neg_q  <= 1'b0;
              dist_q <= 4'd1;
              cnt_q  <= 4'd1;
            end else if (int'(move_count_q) == int'(Cells)) begin
              draw_q <= 1'b1;
              fsm_q  <= StDraw;
            end else begin
              turn_q <= ~turn_q;
              fsm_q  <= StWaitRel;
            end
          end
        end
        StWin, StDraw: begin
          fsm_q <= fsm_q;
        end
        default: fsm_q <= StInit;
      endcase
    end
  end

  assign state_q    = fsm_q;
  assign cur_row    = cur_row_q;
  assign cur_col    = cur_col_q;
  assign turn       = turn_q;
  assign move_count = move_count_q;
  assign busy       = fsm_q[3];
  assign winner     = winner_q;
  assign draw       = draw_q;

endmodule

// File: doc/grid_game_controller.md
Name: grid_game_controller

Overview:
- Parametrised N×N, K-in-a-row two-player board controller; successor to the fixed 3×3 tic-tac-toe controller.
- Owns board state, cursor, turn order and game FSM. Win detection is a sequential scan around the last-placed cell.
- Sits between the debounced button synchroniser and the VGA renderer. Renderer reads cell ownership through a combinational read port; no pixel logic lives here.

Parameters:
- N, 3, board dimension (rows = cols), 3..8
- K, 3, pieces in a line needed to win, 3..N
- CW, $clog2(N), row/col index width, derived, min 1
- MW, $clog2(N*N+1), move counter width, derived

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- up, down, left, right  in  1 each  debounced, synchronised, level-high buttons
- place  in  1  place piece at cursor; level-high
- new_game  in  1  synchronous restart request
- first_player  in  1  sampled in INIT; 0 = A moves first, 1 = B
- rd_row, rd_col  in  CW each  renderer cell query
- rd_owner  out  2  combinational owner of (rd_row, rd_col): 00 empty, 01 A, 10 B; 00 if out of range
- cur_row, cur_col  out  CW each  cursor position; row 0 = top
- turn  out  1  player to move: 0 = A, 1 = B
- move_count  out  MW  pieces on board
- busy  out  1  high in CHECK
- winner  out  2  00 none, 01 A, 10 B
- draw  out  1  board full, no winner
- state_q  out  6  one-hot {DRAW, WIN, CHECK, WAIT_REL, WAIT_PRESS, INIT}

Behaviour:
- Reset values:
  - state INIT; board all 00.
  - cur_row = cur_col = N/2 (integer division).
  - turn 0, move_count 0, winner 00, draw 0, busy 0.
- INIT (1 cycle):
  - Clear board; cursor to centre; turn <= first_player; move_count, winner, draw <= 0.
  - Next state WAIT_PRESS.
- WAIT_PRESS:
  - Input priority: place > right > left > down > up. Only the highest-priority asserted input acts. Any asserted input moves the FSM to WAIT_REL.
  - right: col+1, wraps N-1 -> 0.
  - left: col-1, wraps 0 -> N-1.
  - down: row+1, wraps N-1 -> 0.
  - up: row-1, wraps 0 -> N-1.
  - place on an empty cell: write owner code (turn ? 10 : 01); move_count+1; latch placed cell (pr, pc); next state CHECK.
  - place on an occupied cell: no board, turn or count change; next state WAIT_REL.
- WAIT_REL:
  - Returns to WAIT_PRESS in the cycle after up, down, left, right and place are all low.
  - A held button therefore acts exactly once.
- CHECK (busy = 1; all button inputs ignored):
  - Scan 4 directions in order: horizontal, vertical, main diagonal (+r, +c), anti-diagonal (+r, -c).
  - Each direction has a count starting at 1, a positive arm, then a negative arm.
  - One candidate cell is probed per cycle. In bounds and owner = mover: count+1, step further. Otherwise that cycle ends the arm.
  - An arm also ends after its (K-1)th match, with no terminating probe.
  - When count reaches K, the next state is WIN and winner <= mover code. Remaining arms are skipped.
  - Worst-case CHECK length is 8·(K-1) cycles (8 arms, each at most K-1 probe cycles).
  - Scan completes with no win:
    - If move_count = N·N: draw <= 1, next state DRAW.
    - Otherwise: turn toggles, next state WAIT_REL.
- WIN, DRAW:
  - Board, cursor and flags are frozen; buttons are ignored.
- new_game (all states, including CHECK):
  - Next state INIT. It overrides every other transition in the same cycle.
- rst mid-operation, including mid-CHECK: immediate return to reset values.
- Board storage: 2·N·N flops.
- rd_owner is purely combinational from board state and reflects a write in the cycle after it.

Test Plan:
- Reset, then 1 clk (N=3): state_q = WAIT_PRESS, cursor (1,1), rd_owner 00 for all 9 cells, turn = first_player.
- Wrap: from (1,1), right pulse twice with releases -> (1,2) then (1,0); up from (0,x) -> (2,x). Right held 20 cycles -> single move; a second move only after release.
- Row win (N=3, K=3, first_player 0): A(0,0), B(1,0), A(0,1), B(1,1), A(0,2).
  - Required: winner 01, state WIN, move_count 5.
  - Further place/direction inputs change nothing.
  - new_game -> INIT, then WAIT_PRESS with a cleared board.
- Occupied place: place on a cell owned by A -> turn, move_count and board unchanged; FSM goes to WAIT_REL and no CHECK is entered.
- Draw (N=3): moves A(0,0), B(0,1), A(0,2), B(1,1), A(1,0), B(1,2), A(2,1), B(2,0), A(2,2).
  - Required: draw 1, winner 00, move_count 9, state DRAW.
- N=5, K=4 anti-diagonal win: A fills (0,3), (1,2), (3,0), then (2,1) last.
  - Required: WIN asserted within 8·3 = 24 cycles of entering CHECK.
  - busy high throughout CHECK; button pulses during CHECK are ignored.
  - Assert rst mid-CHECK -> all outputs at reset values.
